// File: rtl/dec_bin.sv
// Sequential 3-digit BCD (0..399) to 9-bit binary converter using reverse double-dabble,
// one right shift per clock under a start/busy/done handshake.
module dec_bin #(
    parameter bit CHECK_BCD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    output logic [8:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Handshake: start is sampled only while busy is low; every accepted request
    // yields exactly one done pulse, with bin/err valid in that cycle and held after.
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [18:0] shift_reg, shift_nxt, shifted;
    logic [3:0]  cnt, cnt_nxt;
    logic [8:0]  bin_nxt;
    logic        err_nxt, done_nxt, busy_nxt;
    logic        bad, bad_nxt, bad_req;

    assign bad_req = CHECK_BCD && ((ten > 4'd9) || (one > 4'd9));

    // One reverse double-dabble step; nibbles are corrected independently, no borrow.
    always_comb begin
        shifted = {1'b0, shift_reg[18:1]};
        if (shifted[16:13] >= 4'd8) shifted[16:13] = shifted[16:13] - 4'd3;
        if (shifted[12:9] >= 4'd8)  shifted[12:9]  = shifted[12:9] - 4'd3;
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = cnt;
        bin_nxt   = bin;
        err_nxt   = err;
        bad_nxt   = bad;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = 4'd0;
                    if (bad_req) begin
                        // Invalid digits: spend one cycle in SHIFT without converting.
                        shift_nxt = '0;
                        bad_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        bin_nxt   = 9'd0;
                    end else begin
                        shift_nxt = {hun, ten, one, 9'b0};
                        bad_nxt   = 1'b0;
                        err_nxt   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (bad) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    shift_nxt = shifted;
                    cnt_nxt   = cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        bin_nxt   = shifted[8:0];
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            bin       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bad       <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            cnt       <= cnt_nxt;
            bin       <= bin_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            bad       <= bad_nxt;
        end
    end

endmodule
